sprite_ram_writer: RTL and testbench
====================================

# sprite_ram_writer

Loads 50×50 tile sprites into the tile sprite RAM that the pixel controller reads during scan-out. It accepts a byte stream of R, G, B triples over a valid/ready handshake and packs each triple into one 32-bit RAM word. It writes one complete tile at a sequential address range selected by a tile index, and reports busy/done/error to the game-logic side.

## Interface
- TILE_W, 50, tile width in pixels
- TILE_H, 50, tile height in pixels
- NUM_TILES, 8, number of tile slots in RAM
- ADDR_W, 16, RAM address width; NUM_TILES·TILE_W·TILE_H ≤ 2^ADDR_W
- clk_vga  input  1  single clock for the whole block (50 MHz)
- reset_n  input  1  reset, synchronous and active-low
- start  input  1  begin loading one tile; sampled only in IDLE
- tile_id  input  8  tile slot to load; latched on accepted start
- s_data  input  8  stream byte
- s_valid  input  1  s_data is valid
- s_ready  output  1  block accepts s_data this cycle
- ram_address  output  ADDR_W  RAM write address
- ram_data  output  32  RAM write word {8'h00, blue, green, red}
- ram_wren  output  1  RAM write strobe, one cycle per pixel
- busy  output  1  high from accepted start until DONE is left
- done  output  1  one-cycle pulse when the tile is complete
- err  output  1  sticky error flag, cleared by the next accepted start

## Operation
- States: IDLE, LOAD, WRITE, CHECK (only when the checksum feature is compiled in), DONE.
- **IDLE:**
  - If start=1 and tile_id < NUM_TILES: latch base = tile_id·TILE_W·TILE_H, clear pixel counter, byte index and err, then go to LOAD.
  - If start=1 and tile_id ≥ NUM_TILES: set err, stay in IDLE, perform no writes.
- **LOAD:**
  - s_ready=1. A byte transfers when s_valid & s_ready.
  - Byte 0 goes to red, byte 1 to green, byte 2 to blue.
  - On the third byte, go to WRITE.
- **WRITE:**
  - s_ready=0, ram_wren=1, ram_address = base + pixel counter, ram_data = {8'h00, b, g, r}.
  - If the counter equals TILE_W·TILE_H−1, go to CHECK (or to DONE when the feature is compiled out). Otherwise increment the counter and return to LOAD.
- **DONE:** done=1 for one cycle, then go to IDLE.
- Pixel order is row-major: counter = y·TILE_W + x, which matches the scan-out address (y%TILE_H)·TILE_W + (x%TILE_W) within a slot.
- start is ignored outside IDLE. tile_id changes after start are ignored.
- s_valid outside LOAD/CHECK is ignored; no byte is consumed.
- Arithmetic: the base multiply uses ADDR_W bits. The counter is ceil(log2(TILE_W·TILE_H)) bits and never wraps past TILE_W·TILE_H−1.

## Timing
- Reset values: s_ready=0, ram_wren=0, ram_address=0, ram_data=0, busy=0, done=0, err=0, state=IDLE.
- busy rises the cycle after an accepted start.
- ram_wren asserts the cycle after the third byte of a pixel is accepted.
- Minimum of 4 cycles per pixel (3 accept cycles + 1 WRITE cycle), so 10 000 cycles minimum per 50×50 tile.
- done follows the cycle after the last write, or after the checksum byte when the feature is compiled in.
- busy falls in the same cycle done is high.
- Stall: s_valid low in LOAD holds the state and byte index indefinitely.
- reset_n low mid-tile: on the next edge, return to reset values. Partially written words remain in RAM; no further writes occur.
- ram_address and ram_data are meaningful only while ram_wren=1. Outside writes they hold their last value.

## Configuration
- SPRITE_WRITER_CHECKSUM_EN defined:
  - An 8-bit modulo-256 sum of all 3·TILE_W·TILE_H data bytes is accumulated.
  - After the last WRITE, go to CHECK with s_ready=1 and accept one checksum byte.
  - On a mismatch, set err; DONE follows either way.
- Undefined: no CHECK state and no checksum byte. err is set only by an invalid tile_id.

## Structure
- Shared package sprite_pkg: TILE_W, TILE_H, TILE_PIXELS, NUM_TILES, the state enum type, and the RGB word pack function {8'h00, b, g, r}, so the pixel controller unpacks with the same layout.
- Sub-module rgb_byte_packer: holds the byte index and the r/g/b registers, and emits a pixel_valid pulse plus the packed word. The FSM instantiates it and owns addressing.

## Test plan
- Reset, then start with tile_id=0, then 7500 bytes with s_valid held high:
  - Exactly 2500 writes at addresses 0..2499.
  - Pixel (x=3, y=1): bytes 0x11, 0x22, 0x33 produce a write at address 53 with data 32'h00332211.
  - done pulses once; total time 10 000 cycles after busy rises.
- tile_id=2 -> first write at address 5000, last write at 7499.
- tile_id=8 -> err=1, busy stays 0, no ram_wren.
- Random s_valid gaps (~30% idle) -> same write sequence as the back-to-back run. s_ready is never high in WRITE.
- reset_n pulled low after pixel 100 -> all outputs return to reset values the next cycle. A fresh start with tile_id=1 then writes from address 2500.
- With SPRITE_WRITER_CHECKSUM_EN, all data bytes 0x01 -> expected sum 7500 mod 256 = 0x4C:
  - Checksum byte 0x4C gives err=0.
  - Checksum byte 0x4D gives err=1.
  - done pulses in both cases.

Source files
------------

// File: rtl/sprite_ram_writer_pkg.sv
// Shared sprite definitions: tile geometry, writer state type and the RAM word layout.
// The pixel controller imports this package, so it unpacks words with the same layout.
package sprite_pkg;

    localparam int TILE_W      = 50;
    localparam int TILE_H      = 50;
    localparam int TILE_PIXELS = TILE_W * TILE_H;
    localparam int NUM_TILES   = 8;
    localparam int ADDR_W      = 16;
    localparam int CNT_W       = $clog2(TILE_PIXELS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WRITE,
        ST_CHECK,
        ST_DONE
    } state_t;

    // RAM word layout: {8'h00, blue, green, red}
    function automatic logic [31:0] pack_rgb(input logic [7:0] r,
                                             input logic [7:0] g,
                                             input logic [7:0] b);
        return {8'h00, b, g, r};
    endfunction

endpackage

// File: rtl/sprite_ram_writer_if.sv
// Byte stream handshake into the sprite writer.
interface sprite_ram_writer_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/sprite_ram_writer_rgb_byte_packer.sv
// Collects R, G, B bytes in order and flags the byte that completes a pixel.
// The packed word is presented combinationally with the blue byte, so the
// caller registers it in the same cycle pixel_valid is high.
module rgb_byte_packer
    import sprite_pkg::*;
(
    input  logic        clk_vga,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic        pixel_valid,
    output logic [31:0] word
);

    logic [1:0] idx_q, idx_d;
    logic [7:0] r_q, r_d;
    logic [7:0] g_q, g_d;

    // Byte index steering and red/green capture.
    always_comb begin
        idx_d = idx_q;
        r_d   = r_q;
        g_d   = g_q;
        if (clear) begin
            idx_d = 2'd0;
        end else if (byte_valid) begin
            case (idx_q)
                2'd0:    begin r_d = byte_in; idx_d = 2'd1; end
                2'd1:    begin g_d = byte_in; idx_d = 2'd2; end
                default: idx_d = 2'd0;
            endcase
        end
    end

    assign pixel_valid = byte_valid && !clear && (idx_q == 2'd2);
    assign word        = pack_rgb(r_q, g_q, byte_in);

    // Byte index and colour registers.
    always_ff @(posedge clk_vga) begin
        if (!reset_n) begin
            idx_q <= 2'd0;
            r_q   <= 8'h00;
            g_q   <= 8'h00;
        end else begin
            idx_q <= idx_d;
            r_q   <= r_d;
            g_q   <= g_d;
        end
    end

endmodule

// File: rtl/sprite_ram_writer.sv
// Sprite RAM writer: streams R,G,B bytes of one 50x50 tile into the tile slot
// chosen by tile_id, one 32-bit word per pixel in row-major order.
// Optional feature macro: SPRITE_WRITER_CHECKSUM_EN adds a trailing checksum
// byte (mod-256 sum of all data bytes); a mismatch sets err.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for start; invalid tile_id sets err
// ST_LOAD  | s_ready high, collecting the three bytes of one pixel
// ST_WRITE | one-cycle RAM write of the packed pixel
// ST_CHECK | s_ready high, waiting for the checksum byte (checksum build)
// ST_DONE  | one-cycle done pulse, then back to idle
module sprite_ram_writer
    import sprite_pkg::*;
(
    input  logic                  clk_vga,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [7:0]            tile_id,
    sprite_ram_writer_if.slave    s,
    output logic [ADDR_W-1:0]     ram_address,
    output logic [31:0]           ram_data,
    output logic                  ram_wren,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam logic [7:0]       MAX_ID   = 8'(NUM_TILES);
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(TILE_PIXELS - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   ram_address_q, ram_address_d;
    logic [31:0]         ram_data_q, ram_data_d;
    logic                s_ready_q, s_ready_d;
    logic                ram_wren_q, ram_wren_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
`ifdef SPRITE_WRITER_CHECKSUM_EN
    logic [7:0]          sum_q, sum_d;
`endif

    logic                accept;
    logic                pack_clear;
    logic                pack_byte;
    logic                pix_valid;
    logic [31:0]         pix_word;

    assign accept    = s.s_valid && s_ready_q;
    assign pack_byte = accept && (state_q == ST_LOAD);

    rgb_byte_packer u_packer (
        .clk_vga     (clk_vga),
        .reset_n     (reset_n),
        .clear       (pack_clear),
        .byte_valid  (pack_byte),
        .byte_in     (s.s_data),
        .pixel_valid (pix_valid),
        .word        (pix_word)
    );

    // Next-state and next-output logic; outputs are registered from the next state.
    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        cnt_d         = cnt_q;
        ram_address_d = ram_address_q;
        ram_data_d    = ram_data_q;
        err_d         = err_q;
        pack_clear    = 1'b0;
`ifdef SPRITE_WRITER_CHECKSUM_EN
        sum_d         = sum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (tile_id < MAX_ID) begin
                        base_d     = ADDR_W'(tile_id) * ADDR_W'(TILE_PIXELS);
                        cnt_d      = '0;
                        err_d      = 1'b0;
                        pack_clear = 1'b1;
`ifdef SPRITE_WRITER_CHECKSUM_EN
                        sum_d      = 8'h00;
`endif
                        state_d    = ST_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
`ifdef SPRITE_WRITER_CHECKSUM_EN
                if (pack_byte) sum_d = sum_q + s.s_data;
`endif
                if (pix_valid) begin
                    ram_address_d = base_q + ADDR_W'(cnt_q);
                    ram_data_d    = pix_word;
                    state_d       = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (cnt_q == LAST_PIX) begin
`ifdef SPRITE_WRITER_CHECKSUM_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ST_LOAD;
                end
            end
`ifdef SPRITE_WRITER_CHECKSUM_EN
            ST_CHECK: begin
                if (accept) begin
                    if (s.s_data != sum_q) err_d = 1'b1;
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        s_ready_d  = (state_d == ST_LOAD) || (state_d == ST_CHECK);
        ram_wren_d = (state_d == ST_WRITE);
        busy_d     = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d     = (state_d == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk_vga) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            base_q        <= '0;
            cnt_q         <= '0;
            ram_address_q <= '0;
            ram_data_q    <= 32'h0;
            s_ready_q     <= 1'b0;
            ram_wren_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
`ifdef SPRITE_WRITER_CHECKSUM_EN
            sum_q         <= 8'h00;
`endif
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            cnt_q         <= cnt_d;
            ram_address_q <= ram_address_d;
            ram_data_q    <= ram_data_d;
            s_ready_q     <= s_ready_d;
            ram_wren_q    <= ram_wren_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
`ifdef SPRITE_WRITER_CHECKSUM_EN
            sum_q         <= sum_d;
`endif
        end
    end

    assign s.s_ready   = s_ready_q;
    assign ram_address = ram_address_q;
    assign ram_data    = ram_data_q;
    assign ram_wren    = ram_wren_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_sprite_ram_writer.sv
// Bench for sprite_ram_writer: scoreboard of expected RAM writes, pushed as
// pixels are streamed in and popped as ram_wren is observed.
// Build with SPRITE_WRITER_CHECKSUM_EN to exercise the checksum byte.
module tb_sprite_ram_writer;

`ifdef SPRITE_WRITER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif
    localparam int PIX = 2500;

    logic        clk_vga = 1'b0;
    logic        reset_n = 1'b0;
    logic        start   = 1'b0;
    logic [7:0]  tile_id = 8'h00;
    logic [15:0] ram_address;
    logic [31:0] ram_data;
    logic        ram_wren, busy, done, err;

    sprite_ram_writer_if sif ();

    sprite_ram_writer dut (
        .clk_vga     (clk_vga),
        .reset_n     (reset_n),
        .start       (start),
        .tile_id     (tile_id),
        .s           (sif.slave),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_wren    (ram_wren),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #10 clk_vga = ~clk_vga;

    typedef struct packed {
        logic [15:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    int          busy_rise_cyc = 0;
    int          done_cyc = 0;
    logic        prev_busy = 1'b0;
    logic [15:0] first_addr = 16'h0;
    logic [15:0] last_addr = 16'h0;
    logic [31:0] data_at_53 = 32'h0;

    // Write monitor / scoreboard consumer
    always @(negedge clk_vga) begin
        wr_t e;
        cyc++;
        if (ram_wren === 1'b1) begin
            if (wr_cnt == 0) first_addr = ram_address;
            last_addr = ram_address;
            wr_cnt++;
            if (ram_address == 16'd53) data_at_53 = ram_data;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: addr=%0d data=%h, no write expected", ram_address, ram_data);
            end else begin
                e = exp_q.pop_front();
                if (ram_address !== e.a || ram_data !== e.d || sif.s_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL write: got addr=%0d data=%h s_ready=%b, want addr=%0d data=%h s_ready=0",
                             ram_address, ram_data, sif.s_ready, e.a, e.d);
                end
            end
        end
        if (busy === 1'b1 && prev_busy !== 1'b1) busy_rise_cyc = cyc;
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        prev_busy = busy;
    end

    function automatic logic [7:0] byte_val(int p, int c, int salt, bit ones);
        if (ones) return 8'h01;
        if (p == 53) return 8'(8'h11 * (c + 1));
        return 8'(p * 7 + c * 13 + salt);
    endfunction

    task automatic do_start(input logic [7:0] t);
        @(negedge clk_vga);
        start   = 1'b1;
        tile_id = t;
    endtask

    // Streams npix pixels (plus a checksum byte when ck_en) honouring s_ready.
    task automatic stream(input int base, input int npix, input int salt, input bit gaps,
                          input bit ones, input bit ck_en, input logic [7:0] ck_delta,
                          output bit ok);
        int nbytes = npix * 3 + (ck_en ? 1 : 0);
        int idx = 0;
        int cycles = 0;
        logic [7:0] r = 8'h0, g = 8'h0, b;
        logic [7:0] sum = 8'h0;
        while (idx < nbytes && cycles < 40000) begin
            @(negedge clk_vga);
            cycles++;
            start   = 1'b0;
            tile_id = 8'hA5;
            if (gaps && $urandom_range(0, 9) < 3) begin
                sif.s_valid = 1'b0;
            end else begin
                sif.s_valid = 1'b1;
                if (idx < npix * 3) sif.s_data = byte_val(idx / 3, idx % 3, salt, ones);
                else                sif.s_data = sum + ck_delta;
                if (sif.s_ready === 1'b1) begin
                    if (idx < npix * 3) begin
                        sum = sum + sif.s_data;
                        case (idx % 3)
                            0: r = sif.s_data;
                            1: g = sif.s_data;
                            default: begin
                                b = sif.s_data;
                                exp_q.push_back({16'(base + idx / 3), {8'h00, b, g, r}});
                            end
                        endcase
                    end
                    idx++;
                end
            end
        end
        ok = (idx == nbytes);
    endtask

    task automatic wait_done(input int d0, output bit ok);
        int n = 0;
        while (done_cnt == d0 && n < 200) begin
            @(negedge clk_vga);
            n++;
        end
        ok = (done_cnt != d0);
        sif.s_valid = 1'b0;
        repeat (4) @(negedge clk_vga);
    endtask

    task automatic run_tile(input logic [7:0] t, input int salt, input bit gaps, input bit ones,
                            input logic [7:0] ck_delta, output int d0);
        bit ok_s, ok_d;
        d0     = done_cnt;
        wr_cnt = 0;
        do_start(t);
        stream(int'(t) * PIX, PIX, salt, gaps, ones, CK, ck_delta, ok_s);
        wait_done(d0, ok_d);
        vectors++;
        if (!ok_s || !ok_d) begin
            miscompares++;
            $display("FAIL tile_%0d_progress: stream_done=%0d done_seen=%0d, want 1 1", t, ok_s, ok_d);
        end
        vectors++;
        if (done_cnt - d0 != 1 || wr_cnt != PIX || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL tile_%0d_counts: done_pulses=%0d writes=%0d pending=%0d, want 1 %0d 0",
                     t, done_cnt - d0, wr_cnt, exp_q.size(), PIX);
        end
        vectors++;
        if (first_addr !== 16'(int'(t) * PIX) || last_addr !== 16'(int'(t) * PIX + PIX - 1)) begin
            miscompares++;
            $display("FAIL tile_%0d_range: first=%0d last=%0d, want %0d %0d",
                     t, first_addr, last_addr, int'(t) * PIX, int'(t) * PIX + PIX - 1);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL tile_%0d_busy_after: busy=%b, want 0", t, busy);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        vectors++;
        if (sif.s_ready !== 1'b0 || ram_wren !== 1'b0 || ram_address !== 16'h0 ||
            ram_data !== 32'h0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: s_ready=%b wren=%b addr=%h data=%h busy=%b done=%b err=%b, want all 0",
                     name, sif.s_ready, ram_wren, ram_address, ram_data, busy, done, err);
        end
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        sif.s_valid = 1'b0;
        sif.s_data  = 8'h00;
        repeat (3) @(negedge clk_vga);
        check_idle_outputs("reset_values");
        reset_n = 1'b1;
        repeat (2) @(negedge clk_vga);
        check_idle_outputs("idle_after_reset");
    endtask

    task automatic test_back_to_back();
        int d0;
        run_tile(8'd0, 0, 1'b0, 1'b0, 8'h00, d0);
        vectors++;
        if (data_at_53 !== 32'h00332211) begin
            miscompares++;
            $display("FAIL pixel_53_data: got %h, want 00332211", data_at_53);
        end
        vectors++;
        if (done_cyc - busy_rise_cyc != (CK ? 10001 : 10000)) begin
            miscompares++;
            $display("FAIL tile_time: got %0d cycles, want %0d", done_cyc - busy_rise_cyc, CK ? 10001 : 10000);
        end
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_after_good_tile: got %b, want 0", err);
        end
    endtask

    task automatic test_tile2();
        int d0;
        run_tile(8'd2, 5, 1'b0, 1'b0, 8'h00, d0);
    endtask

    task automatic test_invalid_tile();
        int w0 = wr_cnt;
        int b_seen = 0;
        do_start(8'd8);
        @(negedge clk_vga);
        start = 1'b0;
        sif.s_valid = 1'b1;
        repeat (6) begin
            @(negedge clk_vga);
            if (busy !== 1'b0 || sif.s_ready !== 1'b0) b_seen++;
        end
        sif.s_valid = 1'b0;
        vectors++;
        if (err !== 1'b1 || b_seen != 0 || wr_cnt != w0) begin
            miscompares++;
            $display("FAIL invalid_tile: err=%b busy_or_ready_cycles=%0d writes=%0d, want 1 0 0",
                     err, b_seen, wr_cnt - w0);
        end
    endtask

    task automatic test_random_gaps();
        int d0;
        run_tile(8'd0, 0, 1'b1, 1'b0, 8'h00, d0);
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_cleared_by_start: got %b, want 0", err);
        end
        vectors++;
        if (data_at_53 !== 32'h00332211) begin
            miscompares++;
            $display("FAIL gaps_pixel_53_data: got %h, want 00332211", data_at_53);
        end
    endtask

    task automatic test_reset_mid_tile();
        bit ok;
        int d0;
        do_start(8'd3);
        stream(3 * PIX, 101, 9, 1'b0, 1'b0, 1'b0, 8'h00, ok);
        @(negedge clk_vga);
        reset_n = 1'b0;
        @(negedge clk_vga);
        check_idle_outputs("reset_mid_tile");
        vectors++;
        if (!ok || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL mid_tile_writes: stream_ok=%0d pending=%0d, want 1 0", ok, exp_q.size());
        end
        exp_q.delete();
        sif.s_valid = 1'b0;
        repeat (2) @(negedge clk_vga);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_vga);
        run_tile(8'd1, 3, 1'b0, 1'b0, 8'h00, d0);
    endtask

`ifdef SPRITE_WRITER_CHECKSUM_EN
    task automatic test_checksum();
        int d0;
        run_tile(8'd4, 0, 1'b0, 1'b1, 8'h00, d0);
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL checksum_good: err=%b, want 0", err);
        end
        run_tile(8'd5, 0, 1'b0, 1'b1, 8'h01, d0);
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL checksum_bad: err=%b, want 1", err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_tile2();
        test_invalid_tile();
        test_random_gaps();
        test_reset_mid_tile();
`ifdef SPRITE_WRITER_CHECKSUM_EN
        test_checksum();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
